// File: rtl/mc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : mc_ctrl_pkg
// Description : Shared state, ALU-operation and opcode encodings for the
//               multicycle controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Base operations fit in 3 bits; the extended set needs the fourth bit.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

`default_nettype wire

// File: rtl/mc_controller_alu_dec.sv
//------------------------------------------------------------------------------
// Module      : alu_dec_p
// Description : funct3/funct7 decode to an ALU operation, width-parameterised.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_dec_p
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  i_op5,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    output logic [ALU_CTRL_W-1:0] o_alu_control
);

    localparam bit C_EXT = (ALU_CTRL_W >= 4);

    logic [3:0] w_op;

    always_comb begin
        w_op = ALU_ADD;
        case (i_funct3)
            3'b000: w_op = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010: w_op = ALU_SLT;
            3'b110: w_op = ALU_OR;
            3'b111: w_op = ALU_AND;
            3'b001: if (C_EXT) w_op = ALU_SLL;
            3'b011: if (C_EXT) w_op = ALU_SLTU;
            3'b100: if (C_EXT) w_op = ALU_XOR;
            3'b101: if (C_EXT) w_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
            default: w_op = ALU_ADD;
        endcase
    end

    assign o_alu_control = ALU_CTRL_W'(w_op);

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
//------------------------------------------------------------------------------
// Module      : mc_controller
// Description : Moore FSM control unit for a multicycle RISC-V style datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit BRANCH_FULL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr
);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_mem_ready;
    logic                    w_cond;
    logic                    w_taken;
    logic [ALU_CTRL_W-1:0]   w_dec_ctrl;

    assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    alu_dec_p #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .i_op5         (op[5]),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .o_alu_control (w_dec_ctrl)
    );

    // funct3[0] inverts the sense; funct3[2:1] selects the flag.
    always_comb begin
        w_cond = 1'b0;
        case (funct3[2:1])
            2'b00:   w_cond = zero;
            2'b10:   w_cond = lt;
            2'b11:   w_cond = ltu;
            default: w_cond = 1'b0;
        endcase
        if (funct3[2:1] == 2'b01)
            w_taken = 1'b0;
        else if (funct3 == 3'b000 || BRANCH_FULL)
            w_taken = w_cond ^ funct3[0];
        else
            w_taken = 1'b0;
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        illegal_instr = 1'b0;
        alu_control   = ALU_CTRL_W'(ALU_ADD);
        case (r_state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = w_mem_ready;
                pc_write   = w_mem_ready;
                if (w_mem_ready) w_next = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECR;
                    OP_ITYPE:          w_next = EXECI;
                    OP_BRANCH:         w_next = BRANCH;
                    OP_JAL:            w_next = JAL;
                    default:           w_next = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (w_mem_ready) w_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (w_mem_ready) w_next = FETCH;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_dec_ctrl;
                w_next      = ALUWB;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_dec_ctrl;
                w_next      = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                w_next    = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_CTRL_W'(ALU_SUB);
                pc_write    = w_taken;
                w_next      = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                w_next    = ALUWB;
            end
            TRAP: begin
                illegal_instr = 1'b1;
                w_next        = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_mc_controller
// Description : Randomised and directed bench for two mc_controller configs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mc_controller;
    import mc_ctrl_pkg::*;

    localparam int P_FETCH = 0, P_DEC = 1, P_MADR = 2, P_MRD = 3, P_MWB = 4,
                   P_MWR = 5, P_EXR = 6, P_EXI = 7, P_AWB = 8, P_BR = 9,
                   P_JAL = 10, P_TRAP = 11;

    logic       clk, rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, mem_ready;

    logic       pcw_a, irw_a, adr_a, mrd_a, mwr_a, rgw_a, ill_a;
    logic [1:0] rs_a, sa_a, sb_a, imm_a;
    logic [2:0] alu_a;
    logic       pcw_b, irw_b, adr_b, mrd_b, mwr_b, rgw_b, ill_b;
    logic [1:0] rs_b, sa_b, sb_b, imm_b;
    logic [3:0] alu_b;

    logic [18:0] pack_a, pack_b;
    assign pack_a = {pcw_a, irw_a, adr_a, mrd_a, mwr_a, rgw_a, rs_a, sa_a, sb_a, imm_a, ill_a, 1'b0, alu_a};
    assign pack_b = {pcw_b, irw_b, adr_b, mrd_b, mwr_b, rgw_b, rs_b, sa_b, sb_b, imm_b, ill_b, alu_b};

    mc_controller dut_a (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pcw_a), .ir_write(irw_a), .adr_src(adr_a), .mem_read(mrd_a),
        .mem_write(mwr_a), .reg_write(rgw_a), .result_src(rs_a), .alu_src_a(sa_a),
        .alu_src_b(sb_a), .imm_src(imm_a), .alu_control(alu_a), .illegal_instr(ill_a)
    );

    mc_controller #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1), .BRANCH_FULL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pcw_b), .ir_write(irw_b), .adr_src(adr_b), .mem_read(mrd_b),
        .mem_write(mwr_b), .reg_write(rgw_b), .result_src(rs_b), .alu_src_a(sa_b),
        .alu_src_b(sb_b), .imm_src(imm_b), .alu_control(alu_b), .illegal_instr(ill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int q[$];
    int c_rw, c_mw, c_ill, c_pa, c_pb, c_cyc;
    logic [3:0] exec_alu_a, exec_alu_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] alu_exp(input logic op5, input logic [2:0] f3, input logic f7, input int w);
        bit ext = (w >= 4);
        case (f3)
            3'b000:  return (op5 && f7) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            3'b001:  return ext ? ALU_SLL : ALU_ADD;
            3'b011:  return ext ? ALU_SLTU : ALU_ADD;
            3'b100:  return ext ? ALU_XOR : ALU_ADD;
            default: return ext ? (f7 ? ALU_SRA : ALU_SRL) : ALU_ADD;
        endcase
    endfunction

    function automatic logic taken_exp(input logic [2:0] f3, input logic z, l, lu, input bit full);
        case (f3)
            3'b000:  return z;
            3'b001:  return full & ~z;
            3'b100:  return full & l;
            3'b101:  return full & ~l;
            3'b110:  return full & lu;
            3'b111:  return full & ~lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [18:0] exp_out(input int ph, input int w, input bit full);
        logic pcw, irw, adr, mrd, mwr, rgw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [3:0] alu;
        {pcw, irw, adr, mrd, mwr, rgw, ill} = '0;
        {rs, sa, sb} = '0;
        alu = ALU_ADD;
        imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
              (op == 7'b1101111) ? 2'b11 : 2'b00;
        case (ph)
            P_FETCH: begin mrd = 1; sb = 2'b10; rs = 2'b10; pcw = mem_ready; irw = mem_ready; end
            P_DEC:   begin sa = 2'b01; sb = 2'b01; end
            P_MADR:  begin sa = 2'b10; sb = 2'b01; end
            P_MRD:   begin adr = 1; mrd = 1; end
            P_MWB:   begin rs = 2'b01; rgw = 1; end
            P_MWR:   begin adr = 1; mwr = 1; end
            P_EXR:   begin sa = 2'b10; alu = alu_exp(op[5], funct3, funct7b5, w); end
            P_EXI:   begin sa = 2'b10; sb = 2'b01; alu = alu_exp(op[5], funct3, funct7b5, w); end
            P_AWB:   rgw = 1;
            P_BR:    begin sa = 2'b10; alu = ALU_SUB; pcw = taken_exp(funct3, zero, lt, ltu, full); end
            P_JAL:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ill = 1;
        endcase
        return {pcw, irw, adr, mrd, mwr, rgw, rs, sa, sb, imm, ill, alu};
    endfunction

    // Phase sequence each instruction class walks through after its fetch.
    task automatic push_path(input logic [6:0] o);
        q.push_back(P_DEC);
        case (o)
            7'b0000011: begin q.push_back(P_MADR); q.push_back(P_MRD); q.push_back(P_MWB); end
            7'b0100011: begin q.push_back(P_MADR); q.push_back(P_MWR); end
            7'b0110011: begin q.push_back(P_EXR); q.push_back(P_AWB); end
            7'b0010011: begin q.push_back(P_EXI); q.push_back(P_AWB); end
            7'b1100011: q.push_back(P_BR);
            7'b1101111: begin q.push_back(P_JAL); q.push_back(P_AWB); end
            default:    q.push_back(P_TRAP);
        endcase
    endtask

    task automatic one_cycle(input logic rdy);
        int ph;
        ph = q[0];
        mem_ready = rdy;
        #1;
        chk($sformatf("outs_a ph%0d", ph), 32'(pack_a), 32'(exp_out(ph, 3, 1'b1)));
        chk($sformatf("outs_b ph%0d", ph), 32'(pack_b), 32'(exp_out(ph, 4, 1'b0)));
        c_rw += int'(rgw_a); c_mw += int'(mwr_a); c_ill += int'(ill_a);
        c_pa += int'(pcw_a); c_pb += int'(pcw_b);
        if (ph == P_EXR || ph == P_EXI) begin
            exec_alu_a = {1'b0, alu_a};
            exec_alu_b = alu_b;
        end
        @(posedge clk);
        if (!((ph == P_FETCH || ph == P_MRD || ph == P_MWR) && !rdy)) begin
            void'(q.pop_front());
            if (ph == P_FETCH) push_path(op);
            if (q.size() == 0) q.push_back(P_FETCH);
        end
        #1;
        c_cyc++;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int stall, input bit rnd, input logic [2:0] flags);
        int  wait_cnt = 0;
        bit  left = 0;
        logic rdy;
        {c_rw, c_mw, c_ill, c_pa, c_pb, c_cyc} = '0;
        op = o; funct3 = f3; funct7b5 = f7;
        while (c_cyc < 40 && !(left && q[0] == P_FETCH)) begin
            if (q[0] == P_FETCH || q[0] == P_MRD || q[0] == P_MWR) begin
                rdy = (wait_cnt >= stall);
                wait_cnt = rdy ? 0 : wait_cnt + 1;
            end else begin
                rdy = 1'($urandom_range(1, 0));
                wait_cnt = 0;
            end
            {zero, lt, ltu} = rnd ? 3'($urandom_range(7, 0)) : flags;
            one_cycle(rdy);
            if (q[0] != P_FETCH) left = 1;
        end
        chk("instr_done", 32'(left && q[0] == P_FETCH), 32'd1);
    endtask

    logic [6:0] ops [8];

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1111111, 7'b0010111};
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        exec_alu_a = '0; exec_alu_b = '0;
        q.push_back(P_FETCH);
        #2;
        chk("reset_a", 32'(pack_a), 32'(exp_out(P_FETCH, 3, 1'b1)));
        chk("reset_b", 32'(pack_b), 32'(exp_out(P_FETCH, 4, 1'b0)));
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(7'b0000011, 3'b010, 1'b0, 2, 1'b1, 3'b000);
        chk("lw_cycles", 32'(c_cyc), 32'd9);
        chk("lw_regwrite", 32'(c_rw), 32'd1);

        run_instr(7'b0100011, 3'b010, 1'b0, 0, 1'b1, 3'b000);
        chk("sw_memwrite", 32'(c_mw), 32'd1);
        chk("sw_regwrite", 32'(c_rw), 32'd0);
        chk("sw_imm", 32'(imm_a), 32'd1);

        run_instr(7'b1100011, 3'b001, 1'b0, 0, 1'b0, 3'b000);
        chk("bne_nz_pcw", 32'(c_pa), 32'd2);
        run_instr(7'b1100011, 3'b001, 1'b0, 0, 1'b0, 3'b100);
        chk("bne_z_pcw", 32'(c_pa), 32'd1);
        run_instr(7'b1100011, 3'b110, 1'b0, 0, 1'b0, 3'b001);
        chk("bltu_full_pcw", 32'(c_pa), 32'd2);
        chk("bltu_beqonly_pcw", 32'(c_pb), 32'd1);

        run_instr(7'b0110011, 3'b000, 1'b1, 0, 1'b1, 3'b000);
        chk("rsub_alu", 32'(exec_alu_a), 32'(ALU_SUB));
        run_instr(7'b0110011, 3'b101, 1'b1, 1, 1'b1, 3'b000);
        chk("rsra_alu_w4", 32'(exec_alu_b), 32'(ALU_SRA));

        run_instr(7'b1111111, 3'b000, 1'b0, 0, 1'b1, 3'b000);
        chk("illegal_pulse", 32'(c_ill), 32'd1);
        chk("illegal_cycles", 32'(c_cyc), 32'd3);

        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; {zero, lt, ltu} = 3'b000;
        one_cycle(1'b1); one_cycle(1'b1); one_cycle(1'b1);
        mem_ready = 1'b0;
        #1;
        chk("mw_before_rst", 32'(mwr_a), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mw_in_rst_a", 32'(mwr_a), 32'd0);
        chk("mw_in_rst_b", 32'(mwr_b), 32'd0);
        chk("fetch_in_rst", 32'({mrd_a, pcw_a, irw_a}), 32'b100);
        q.delete();
        q.push_back(P_FETCH);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 1'b1, 3'b000);
        chk("lw_after_rst", 32'(c_cyc), 32'd5);

        for (int i = 0; i < 200; i++) begin
            run_instr(ops[$urandom_range(7, 0)], 3'($urandom_range(7, 0)),
                      1'($urandom_range(1, 0)), $urandom_range(2, 0), 1'b1, 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
